// File: rtl/seg7_rx_decode.sv
// Receive-side 7-segment decoder: registers an active-low pattern bus, waits for it
// to hold steady, decodes it to an octal digit and hands it off via valid/ready.
module seg7_rx_decode #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [6:0] seg_i,
   input  logic       en_i,
   input  logic       ready_i,
   input  logic       clr_i,
   output logic [2:0] digit_o,
   output logic       valid_o,
   output logic       err_o,
   output logic       blank_o,
   output logic       overrun_o,
   output logic [7:0] count_o
);

   typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

   localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

   state_t     state, state_n;
   logic [6:0] s1, cand, cand_n;
   logic [7:0] cnt, cnt_n;
   logic       accept;
   logic [2:0] code;
   logic       code_ok;
   logic       is_blank;
   logic       acc_digit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1    <= 7'h7F;
         cand  <= 7'h7F;
         cnt   <= '0;
         state <= IDLE;
      end else begin
         s1    <= seg_i;
         cand  <= cand_n;
         cnt   <= cnt_n;
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      accept  = 1'b0;
      if (!en_i) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               cand_n  = s1;
               cnt_n   = '0;
               state_n = TRACK;
            end
            TRACK: begin
               if (s1 != cand) begin
                  cand_n = s1;
                  cnt_n  = '0;
               end else if (cnt == LAST_CNT) begin
                  accept  = 1'b1;
                  state_n = LOCKED;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            LOCKED: begin
               if (s1 != cand) begin
                  cand_n  = s1;
                  cnt_n   = '0;
                  state_n = TRACK;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      code    = '0;
      code_ok = 1'b1;
      unique case (cand)
         7'b1000000: code = 3'd0;
         7'b1111001: code = 3'd1;
         7'b0100100: code = 3'd2;
         7'b0110000: code = 3'd3;
         7'b0011001: code = 3'd4;
         7'b0010010: code = 3'd5;
         7'b0000011: code = 3'd6;
         7'b1111000: code = 3'd7;
         default:    code_ok = 1'b0;
      endcase
   end

   assign is_blank  = (cand == 7'h7F);
   assign acc_digit = accept && code_ok;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digit_o   <= '0;
         valid_o   <= 1'b0;
         err_o     <= 1'b0;
         blank_o   <= 1'b0;
         overrun_o <= 1'b0;
         count_o   <= '0;
      end else begin
         err_o <= accept && !code_ok && !is_blank;
         if (acc_digit) begin
            digit_o <= code;
            valid_o <= 1'b1;
            blank_o <= 1'b0;
         end else begin
            if (valid_o && ready_i) valid_o <= 1'b0;
            if (accept) blank_o <= is_blank;
         end
         // clear outranks a simultaneous overrun; a coincident accept still counts once
         if (clr_i) begin
            overrun_o <= 1'b0;
            count_o   <= acc_digit ? 8'd1 : 8'd0;
         end else begin
            if (acc_digit && valid_o && !ready_i) overrun_o <= 1'b1;
            if (acc_digit) count_o <= count_o + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_rx_decode.sv
// Randomised and directed bench for seg7_rx_decode against a run-length reference model.
module tb_seg7_rx_decode;

   localparam int S = 4;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [6:0] seg_i = 7'h7F;
   logic       en_i = 1'b0;
   logic       ready_i = 1'b0;
   logic       clr_i = 1'b0;
   logic [2:0] digit_o;
   logic       valid_o;
   logic       err_o;
   logic       blank_o;
   logic       overrun_o;
   logic [7:0] count_o;

   int n_tests = 0;
   int n_fail  = 0;
   int err_seen = 0;

   seg7_rx_decode #(.STABLE_CYCLES(S)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .seg_i(seg_i), .en_i(en_i),
      .ready_i(ready_i), .clr_i(clr_i), .digit_o(digit_o), .valid_o(valid_o),
      .err_o(err_o), .blank_o(blank_o), .overrun_o(overrun_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   logic [6:0] tbl [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000011, 7'b1111000};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a pattern is accepted when the registered sample has shown it on
   // exactly S+1 consecutive enabled edges.
   logic [6:0] m_s1 = 7'h7F, run_pat = 7'h7F;
   int         run = 0;
   logic [2:0] m_digit = '0;
   logic       m_valid = 1'b0, m_err = 1'b0, m_blank = 1'b0, m_over = 1'b0;
   logic [7:0] m_count = '0;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_s1 <= 7'h7F; run_pat <= 7'h7F; run <= 0;
         m_digit <= '0; m_valid <= 1'b0; m_err <= 1'b0;
         m_blank <= 1'b0; m_over <= 1'b0; m_count <= '0;
      end else begin : mdl
         automatic int         r    = run;
         automatic logic [6:0] rp   = run_pat;
         automatic logic [7:0] c    = m_count;
         automatic logic       v    = m_valid;
         automatic logic [2:0] d    = m_digit;
         automatic logic       b    = m_blank;
         automatic logic       o    = m_over;
         automatic logic       e    = 1'b0;
         automatic logic       good = 1'b0;
         automatic int         idx  = -1;
         if (!en_i) r = 0;
         else if (r > 0 && m_s1 == rp) r = (r < S + 2) ? r + 1 : r;
         else begin r = 1; rp = m_s1; end
         if (m_valid && ready_i) v = 1'b0;
         if (en_i && r == S + 1) begin
            for (int k = 0; k < 8; k++) if (tbl[k] == rp) idx = k;
            if (idx >= 0) begin
               good = 1'b1;
               if (m_valid && !ready_i) o = 1'b1;
               v = 1'b1; d = 3'(idx); b = 1'b0; c = c + 8'd1;
            end else if (rp == 7'h7F) b = 1'b1;
            else begin e = 1'b1; b = 1'b0; end
         end
         if (clr_i) begin o = 1'b0; c = good ? 8'd1 : 8'd0; end
         run <= r; run_pat <= rp; m_s1 <= seg_i;
         m_digit <= d; m_valid <= v; m_err <= e; m_blank <= b; m_over <= o; m_count <= c;
      end
   end

   always @(negedge clk_i) begin
      check_eq("digit", 32'(digit_o), 32'(m_digit));
      check_eq("valid", 32'(valid_o), 32'(m_valid));
      check_eq("err", 32'(err_o), 32'(m_err));
      check_eq("blank", 32'(blank_o), 32'(m_blank));
      check_eq("overrun", 32'(overrun_o), 32'(m_over));
      check_eq("count", 32'(count_o), 32'(m_count));
   end

   always @(posedge clk_i) begin
      #1;
      if (err_o) err_seen++;
   end

   task automatic do_reset();
      rst_ni = 1'b0; en_i = 1'b0; ready_i = 1'b0; clr_i = 1'b0; seg_i = 7'h7F;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic hold(input logic [6:0] pat, input int n);
      seg_i = pat;
      repeat (n) @(negedge clk_i);
   endtask

   task automatic async_reset_check(input string tag);
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check_eq({tag, "_valid"}, 32'(valid_o), 0);
      check_eq({tag, "_digit"}, 32'(digit_o), 0);
      check_eq({tag, "_count"}, 32'(count_o), 0);
      check_eq({tag, "_blank"}, 32'(blank_o), 0);
      check_eq({tag, "_over"}, 32'(overrun_o), 0);
      check_eq({tag, "_err"}, 32'(err_o), 0);
      @(negedge clk_i);
      en_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      do_reset();
      check_eq("rst_valid", 32'(valid_o), 0);
      check_eq("rst_count", 32'(count_o), 0);

      // single digit, ready low
      en_i = 1'b1;
      hold(7'b0100100, 5);
      check_eq("t1_not_yet", 32'(valid_o), 0);
      hold(7'b0100100, 5);
      check_eq("t1_valid", 32'(valid_o), 1);
      check_eq("t1_digit", 32'(digit_o), 2);
      check_eq("t1_count", 32'(count_o), 1);

      // sweep of all table patterns
      do_reset();
      en_i = 1'b1; ready_i = 1'b1; err_seen = 0;
      for (int k = 0; k < 8; k++) hold(tbl[k], 8);
      check_eq("sweep_count", 32'(count_o), 8);
      check_eq("sweep_over", 32'(overrun_o), 0);
      check_eq("sweep_err", 32'(err_seen), 0);

      // glitch restarts the count
      do_reset();
      en_i = 1'b1;
      hold(7'b0110000, 3);
      hold(7'b0011001, 8);
      check_eq("glitch_count", 32'(count_o), 1);
      check_eq("glitch_digit", 32'(digit_o), 4);

      // invalid then blank
      do_reset();
      en_i = 1'b1; err_seen = 0;
      hold(7'b0000000, 8);
      check_eq("inv_err_pulses", 32'(err_seen), 1);
      check_eq("inv_valid", 32'(valid_o), 0);
      hold(7'h7F, 8);
      check_eq("blank_lvl", 32'(blank_o), 1);
      check_eq("blank_count", 32'(count_o), 0);

      // overrun, clear, consume
      do_reset();
      en_i = 1'b1;
      hold(7'b1111001, 8);
      hold(7'b0010010, 8);
      check_eq("ovr_flag", 32'(overrun_o), 1);
      check_eq("ovr_digit", 32'(digit_o), 5);
      clr_i = 1'b1;
      @(negedge clk_i);
      clr_i = 1'b0;
      check_eq("clr_over", 32'(overrun_o), 0);
      check_eq("clr_count", 32'(count_o), 0);
      check_eq("clr_valid", 32'(valid_o), 1);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      check_eq("consume_valid", 32'(valid_o), 0);

      // asynchronous reset mid-TRACK with a pending digit, then while locked
      do_reset();
      en_i = 1'b1;
      hold(7'b0110000, 8);
      hold(7'b0000011, 3);
      async_reset_check("rst_track");
      en_i = 1'b1;
      hold(7'b1111000, 8);
      check_eq("pre_rst_valid", 32'(valid_o), 1);
      async_reset_check("rst_valid");

      // randomised traffic
      for (int i = 0; i < 300; i++) begin
         automatic int         sel = $urandom_range(0, 19);
         automatic int         len = $urandom_range(1, 10);
         automatic logic [6:0] pat;
         if (sel < 14) pat = tbl[$urandom_range(0, 7)];
         else if (sel < 17) pat = 7'h7F;
         else pat = 7'($urandom);
         for (int j = 0; j < len; j++) begin
            seg_i   = pat;
            en_i    = ($urandom_range(0, 9) != 0);
            ready_i = 1'($urandom_range(0, 1));
            clr_i   = ($urandom_range(0, 19) == 0);
            @(negedge clk_i);
         end
      end
      clr_i = 1'b0;
      @(negedge clk_i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_rx_decode.md
# seg7_rx_decode

Receive-side counterpart to the team's octal-to-7-segment encoder. Samples an active-low 7-segment pattern bus, requires the pattern to be stable for a programmable number of clocks, and decodes it back to a 3-bit octal digit. Results go to a consumer through a valid/ready handshake, with error, blank and overrun reporting. Used for loopback checking of display outputs and for reading pattern buses driven by other boards.

## Interface
- STABLE_CYCLES, default 4: consecutive matching samples (after candidate capture) needed to accept a pattern; legal range 1..255.
- clk_i  input  1  system clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- seg_i  input  7  active-low segment pattern, bit0=a .. bit6=g (0 = segment lit).
- en_i  input  1  sampling enable.
- ready_i  input  1  consumer accepts digit_o when valid_o && ready_i at a rising edge.
- clr_i  input  1  synchronous clear of count_o and overrun_o.
- digit_o  output  3  last accepted octal digit.
- valid_o  output  1  digit_o holds an unconsumed digit.
- err_o  output  1  one-cycle pulse: an unrecognised pattern was accepted.
- blank_o  output  1  level: the last accepted pattern was 7'b1111111.
- overrun_o  output  1  sticky: a new digit replaced an unconsumed one.
- count_o  output  8  number of accepted valid digits, modulo 256.

## Operation
- Decode table (seg_i to digit): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000011->6, 1111000->7. Any other pattern except 1111111 is invalid.
- The input is always registered into s1. All decisions use s1, never seg_i directly.
- Internal registers: candidate pattern cand (7 bits) and stability counter cnt (8 bits).
- FSM states are IDLE, TRACK and LOCKED. Reset state is IDLE.
- IDLE: when en_i=1, set cand<=s1, cnt<=0 and go to TRACK.
- TRACK, s1!=cand: set cand<=s1, cnt<=0.
- TRACK, s1==cand and cnt<STABLE_CYCLES-1: cnt<=cnt+1.
- TRACK, s1==cand and cnt==STABLE_CYCLES-1: accept cand and go to LOCKED.
- LOCKED, s1==cand: hold. A stable pattern is accepted exactly once.
- LOCKED, s1!=cand: set cand<=s1, cnt<=0 and go to TRACK.
- en_i=0 in any state: go to IDLE and clear cnt. valid_o, digit_o, blank_o, overrun_o and count_o hold their values.
- Accept of a valid digit:
  - digit_o<=code, valid_o<=1, blank_o<=0, count_o<=count_o+1 (255 wraps to 0).
  - If valid_o=1 and ready_i=0 at that edge, set overrun_o.
- Accept of blank (1111111): blank_o<=1. No change to valid_o, digit_o or count_o.
- Accept of an invalid pattern: err_o=1 for exactly one cycle and blank_o<=0. No other change.
- Handshake:
  - valid_o && ready_i at an edge clears valid_o, unless a valid accept occurs at the same edge. In that case valid_o stays 1, digit_o takes the new code, and overrun_o is not set.
  - digit_o is stable while valid_o=1, except when overwritten on overrun.
- clr_i: count_o<=0 and overrun_o<=0. If a valid accept occurs at the same edge, count_o<=1.

## Timing
- Reset values: digit_o=0, valid_o=0, err_o=0, blank_o=0, overrun_o=0, count_o=0, s1=7'h7F, cand=7'h7F, cnt=0, state IDLE.
- Latency (state TRACK or LOCKED with cand!=P):
  - Pattern P first captured into s1 at edge 1.
  - cand<=P at edge 2.
  - Accept at edge STABLE_CYCLES+2, so outputs update after that edge. With the default, that is edge 6.
  - seg_i must equal P at edges 1..STABLE_CYCLES+1.
- Any change of s1 before acceptance restarts the count from the new pattern, with no output activity.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset asserted mid-operation returns every register to its reset value immediately. A pending digit is lost.

## Test plan
- Reset, en_i=1, hold seg_i=0100100 for 10 clocks with ready_i=0 -> valid_o rises after edge 6, digit_o=2, count_o=1, and no second accept while the pattern is held.
- Sweep all 8 table patterns, each held 8 clocks, with ready_i=1 -> digits 0..7 each delivered once, count_o=8, err_o never pulses, overrun_o=0.
- Glitch: 0110000 held 3 clocks, then 0011001 held 8 clocks (STABLE_CYCLES=4) -> only digit 4 is accepted, count_o=1.
- seg_i=0000000 held 8 clocks -> err_o is a single-cycle pulse and valid_o is unchanged. Then 1111111 held 8 clocks -> blank_o=1, count_o unchanged.
- ready_i=0: deliver 1 then 5 -> overrun_o=1, digit_o=5. Pulse clr_i -> overrun_o=0, count_o=0, valid_o still 1. Assert ready_i for one edge -> valid_o=0.
- Assert rst_ni low midway through a TRACK count, and separately with valid_o=1 -> all outputs return to reset values within the same cycle, asynchronously.
